// File: rtl/rex_pkg.sv
// ============================================================================
// Module      : rex_pkg
// Description : Shared constants, sprite bitmap and state type for the frame composer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rex_pkg;

    localparam int LCD_COLS   = 128;
    localparam int LCD_ROWS   = 64;
    localparam int CHIP_W     = 1;
    localparam int PAGE_W     = 3;
    localparam int COL_W      = 6;
    localparam int ADDR_W     = CHIP_W + PAGE_W + COL_W;
    localparam int BANK_BYTES = 1 << ADDR_W;

    // Index [row][col]; row 0 is the top of the sprite and is listed last.
    localparam logic [7:0][7:0] DINO_BMP = {
        8'h24, 8'h3C, 8'h7F, 8'h3E, 8'hFC, 8'hBC, 8'hFC, 8'h78
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RENDER   = 2'd1,
        ST_WAIT_GAP = 2'd2,
        ST_SWAP     = 2'd3
    } fc_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_byte.sv
// ============================================================================
// Module      : pixel_byte
// Description : Combinational renderer of one frame-store byte (8 vertical pixels).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pixel_byte
    import rex_pkg::*;
#(
    parameter int GROUND_ROW = 56,
    parameter int DINO_COL   = 8,
    parameter int OBST_W     = 6,
    parameter int OBST_H     = 12
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [5:0]        dino_row_i,
    input  logic [6:0]        obst_col_i,
    output logic [7:0]        byte_o
);

    logic [6:0]        col;
    logic [PAGE_W-1:0] page;

    assign col  = {addr_i[ADDR_W-1], addr_i[COL_W-1:0]};
    assign page = addr_i[COL_W +: PAGE_W];

    // Row bounds use 7 bits and column bounds 8 bits so sprites clip, never wrap.
    function automatic logic pix_on(input logic [5:0] row, input logic [6:0] c,
                                    input logic [5:0] drow, input logic [6:0] ocol);
        logic [6:0] r7, d7, dr7;
        logic [7:0] c8, o8;
        logic [2:0] bx, by;
        logic       ground, dino, obst;
        r7     = {1'b0, row};
        d7     = {1'b0, drow};
        dr7    = r7 - d7;
        c8     = {1'b0, c};
        o8     = {1'b0, ocol};
        by     = dr7[2:0];
        bx     = 3'(c - 7'(DINO_COL));
        ground = (row == 6'(GROUND_ROW));
        dino   = (c >= 7'(DINO_COL)) && (c8 < 8'(DINO_COL + 8)) &&
                 (r7 >= d7) && (r7 < d7 + 7'd8) && DINO_BMP[by][bx];
        obst   = (c8 >= o8) && (c8 < o8 + 8'(OBST_W)) &&
                 (r7 >= 7'(GROUND_ROW - OBST_H)) && (r7 < 7'(GROUND_ROW));
        return ground | dino | obst;
    endfunction

    always_comb begin
        byte_o = '0;
        for (int b = 0; b < 8; b++) begin
            byte_o[b] = pix_on({page, 3'(b)}, col, dino_row_i, obst_col_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_composer.sv
// ============================================================================
// Module      : frame_composer
// Description : Renders a game frame into a double-buffered frame store and hands it to the LCD driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_composer
    import rex_pkg::*;
#(
    parameter int GROUND_ROW = 56,
    parameter int DINO_COL   = 8,
    parameter int OBST_W     = 6,
    parameter int OBST_H     = 12,
    parameter int MIN_GAP    = 20000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_i,
    input  logic [5:0]        dino_row_i,
    input  logic [6:0]        obst_col_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [7:0]        data_o,
    output logic              start_o,
    output logic              busy_o
);

    localparam int GAP_W = $clog2(MIN_GAP);

    fc_state_t         state_q, state_d;
    logic              front_q, front_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [5:0]        dino_q, dino_d;
    logic [6:0]        obst_q, obst_d;
    logic [7:0]        pix_byte;

    logic [7:0] mem [2*BANK_BYTES];

    pixel_byte #(
        .GROUND_ROW (GROUND_ROW),
        .DINO_COL   (DINO_COL),
        .OBST_W     (OBST_W),
        .OBST_H     (OBST_H)
    ) u_pixel_byte (
        .addr_i     (wcnt_q),
        .dino_row_i (dino_q),
        .obst_col_i (obst_q),
        .byte_o     (pix_byte)
    );

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        wcnt_d  = wcnt_q;
        start_d = start_q;
        dino_d  = dino_q;
        obst_d  = obst_q;
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_i) begin
                    dino_d  = dino_row_i;
                    obst_d  = obst_col_i;
                    wcnt_d  = '0;
                    start_d = 1'b1;
                    state_d = ST_RENDER;
                end
            end
            ST_RENDER: begin
                wcnt_d = wcnt_q + ADDR_W'(1);
                if (wcnt_q == '1) begin
                    state_d = ST_WAIT_GAP;
                end
            end
            ST_WAIT_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                front_d = ~front_q;
                start_d = 1'b0;
                gap_d   = GAP_W'(MIN_GAP - 1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            front_q <= 1'b0;
            wcnt_q  <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            dino_q  <= '0;
            obst_q  <= '0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            wcnt_q  <= wcnt_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            dino_q  <= dino_d;
            obst_q  <= obst_d;
        end
    end

    // Frame store has no reset: the driver never reads it before the first swap.
    always_ff @(posedge clk) begin
        if (state_q == ST_RENDER) begin
            mem[{~front_q, wcnt_q}] <= pix_byte;
        end
    end

    assign data_o  = mem[{front_q, addr_i}];
    assign start_o = start_q;
    assign busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_composer.sv
// ============================================================================
// Module      : tb_frame_composer
// Description : Self-checking bench with a timeline/pixel reference model for frame_composer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_composer;

    localparam int GROUND_ROW = 56;
    localparam int DINO_COL   = 8;
    localparam int OBST_W     = 6;
    localparam int OBST_H     = 12;
    localparam int MIN_GAP    = 2000;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       frame_i = 1'b0;
    logic [5:0] dino_row_i = '0;
    logic [6:0] obst_col_i = '0;
    logic [9:0] addr_i = '0;
    logic [7:0] data_o;
    logic       start_o;
    logic       busy_o;

    int checks = 0;
    int failures = 0;

    frame_composer #(
        .GROUND_ROW (GROUND_ROW),
        .DINO_COL   (DINO_COL),
        .OBST_W     (OBST_W),
        .OBST_H     (OBST_H),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .frame_i    (frame_i),
        .dino_row_i (dino_row_i),
        .obst_col_i (obst_col_i),
        .addr_i     (addr_i),
        .data_o     (data_o),
        .start_o    (start_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    logic [7:0] bmp [8] = '{8'h78, 8'hFC, 8'hBC, 8'hFC, 8'h3E, 8'h7F, 8'h3C, 8'h24};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected byte straight from the screen-pixel rules, in plain integers.
    function automatic logic [7:0] exp_byte(input int a, input int dr, input int oc);
        logic [7:0] v;
        int c, page, r;
        v    = '0;
        c    = (a / 512) * 64 + (a % 64);
        page = (a / 64) % 8;
        for (int b = 0; b < 8; b++) begin
            r = page * 8 + b;
            if (r == GROUND_ROW) v[b] = 1'b1;
            if (c >= DINO_COL && c < DINO_COL + 8 && r >= dr && r < dr + 8 && bmp[r - dr][c - DINO_COL])
                v[b] = 1'b1;
            if (c >= oc && c < oc + OBST_W && r >= GROUND_ROW - OBST_H && r < GROUND_ROW)
                v[b] = 1'b1;
        end
        return v;
    endfunction

    // Reference model: frame timeline as event arithmetic plus per-bank byte images.
    int         m_cyc = 0;
    bit         m_active = 1'b0;
    bit         m_front = 1'b0;
    int         m_accept = 0;
    int         m_swap_at = 0;
    int         m_last_swap = -1000000;
    int         m_dr = 0;
    int         m_oc = 0;
    int         m_k = 0;
    logic [7:0] m_mem [2][1024];
    bit         m_valid [2][1024];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active    = 1'b0;
            m_front     = 1'b0;
            m_last_swap = -1000000;
        end else begin
            m_cyc++;
            if (m_active) begin
                m_k = m_cyc - m_accept - 1;
                if (m_k >= 0 && m_k < 1024) begin
                    m_mem[!m_front][m_k]   = exp_byte(m_k, m_dr, m_oc);
                    m_valid[!m_front][m_k] = 1'b1;
                end
                if (m_cyc == m_swap_at) begin
                    m_active    = 1'b0;
                    m_front     = !m_front;
                    m_last_swap = m_cyc;
                end
            end else if (frame_i) begin
                m_active  = 1'b1;
                m_accept  = m_cyc;
                m_dr      = int'(dino_row_i);
                m_oc      = int'(obst_col_i);
                m_swap_at = (m_cyc + 1026 > m_last_swap + MIN_GAP + 1) ? m_cyc + 1026
                                                                       : m_last_swap + MIN_GAP + 1;
            end
        end
    end

    bit prev_start = 1'b0;
    int falls = 0;
    int last_fall = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("reset_start", start_o, 0);
            chk("reset_busy", busy_o, 0);
        end else begin
            chk("start", start_o, m_active);
            chk("busy", busy_o, m_active);
            if (prev_start && !start_o) begin
                falls++;
                last_fall = m_cyc;
            end
        end
        prev_start = start_o;
    end

    task automatic pulse_frame(input int dr, input int oc);
        @(negedge clk);
        dino_row_i = 6'(dr);
        obst_col_i = 7'(oc);
        frame_i    = 1'b1;
        @(negedge clk);
        frame_i    = 1'b0;
    endtask

    task automatic wait_until(input int target, input string name);
        int n = 0;
        while (m_cyc < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (m_cyc < target) begin
            checks++;
            failures++;
            $display("FAIL %s timeout cyc=%0d target=%0d", name, m_cyc, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o !== 1'b0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s idle timeout busy=%b expected=0", name, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 1024; a++) begin
            addr_i = 10'(a);
            #1;
            if (m_valid[m_front][a]) chk(name, data_o, m_mem[m_front][a]);
        end
    endtask

    task automatic peek(input string name, input int a, input int exp);
        addr_i = 10'(a);
        #1;
        chk(name, data_o, exp);
    endtask

    int acc_a, swap_a, swap_b, acc_d, acc_e;

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("idle_start", start_o, 0);
        chk("idle_busy", busy_o, 0);

        // Frame A, with frame_i pulsed during RENDER and during SWAP.
        pulse_frame(40, 100);
        acc_a = m_cyc;
        chk("start_rise", start_o, 1);
        repeat (300) @(negedge clk);
        pulse_frame(3, 3);
        wait_until(acc_a + 1025, "swap_cycle_a");
        frame_i = 1'b1;
        @(negedge clk);
        frame_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("fall_latency", last_fall - acc_a, 1026);
        chk("one_fall", falls, 1);
        swap_a = last_fall;
        sweep("frame_a");
        peek("ground_byte", 0 * 512 + 7 * 64 + 0, 8'h01);
        peek("obst_p5_c36", 1 * 512 + 5 * 64 + 36, 8'hF0);
        peek("obst_p5_c41", 1 * 512 + 5 * 64 + 41, 8'hF0);
        peek("obst_p6_c36", 1 * 512 + 6 * 64 + 36, 8'hFF);
        peek("obst_p5_c42", 1 * 512 + 5 * 64 + 42, 8'h00);

        // Frame B inside the gap window; front must hold frame A meanwhile.
        pulse_frame(60, 125);
        wait_until(m_accept + 1100, "wait_gap_b");
        chk("busy_in_gap", busy_o, 1);
        sweep("hold_front_a");
        swap_b = m_swap_at;
        wait_until(swap_b - 1, "swap_cycle_b");
        dino_row_i = 6'($urandom_range(0, 63));
        obst_col_i = 7'($urandom_range(0, 127));
        frame_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_i = 1'b0;
        chk("accept_first_idle", busy_o, 1);
        chk("gap_spacing_b", last_fall - swap_a, MIN_GAP + 1);
        sweep("frame_b");
        peek("dino_clip_p7", 0 * 512 + 7 * 64 + 11, 8'hF1);
        peek("dino_nowrap_p0", 0 * 512 + 0 * 64 + 8, 8'h00);
        peek("obst_c125", 1 * 512 + 6 * 64 + 61, 8'hFF);
        peek("obst_c127", 1 * 512 + 6 * 64 + 63, 8'hFF);
        peek("obst_nowrap_c0", 0 * 512 + 6 * 64 + 0, 8'h00);

        // Frame C completes; its spacing follows from the swap of B.
        wait_idle("frame_c");
        chk("gap_spacing_c", last_fall - swap_b, MIN_GAP + 1);
        sweep("frame_c");

        // Frame D interrupted by reset after 500 bytes.
        pulse_frame($urandom_range(0, 63), $urandom_range(0, 127));
        acc_d = m_cyc;
        wait_until(acc_d + 500, "render_500");
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_start", start_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        sweep("rst_front0");
        @(negedge clk);
        #2 rstn = 1'b1;

        // Frame E after reset: gap counter cleared, full latency only.
        pulse_frame($urandom_range(0, 63), $urandom_range(0, 127));
        acc_e = m_cyc;
        wait_idle("frame_e");
        chk("fall_after_reset", last_fall - acc_e, 1026);
        sweep("frame_e");

        // Randomized frame requests, including many while busy.
        for (int i = 0; i < 4; i++) begin
            pulse_frame($urandom_range(0, 63), $urandom_range(0, 127));
            for (int j = 0; j < 1500; j++) begin
                @(negedge clk);
                frame_i    = ($urandom_range(0, 39) == 0);
                dino_row_i = 6'($urandom_range(0, 63));
                obst_col_i = 7'($urandom_range(0, 127));
            end
            @(negedge clk);
            frame_i = 1'b0;
            wait_idle("rand_idle");
            sweep("rand_frame");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
